// File: rtl/npn4_pkg.sv
// Shared types and constants for the 4-input NPN truth-table capture stage.
package npn4_pkg;

    localparam int unsigned TT_W = 16;
    localparam int unsigned N_IN = 4;

    // Identity permutation: sweep bit i drives x[i].
    localparam logic [7:0] PERM_ID = 8'hE4;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StDrive,
        StSettle,
        StSample,
        StFinish
    } state_e;

    // A permutation is a bijection on {0..3} exactly when every target index is hit.
    function automatic logic perm_valid(input logic [7:0] p);
        logic [N_IN-1:0] seen;
        seen = '0;
        for (int i = 0; i < N_IN; i++) begin
            seen[p[2*i+:2]] = 1'b1;
        end
        return &seen;
    endfunction

endpackage

// File: rtl/npn4_input_map.sv
// Combinational NPN input transform: sweep index -> network x inputs.
module npn4_input_map
    import npn4_pkg::*;
(
    input  logic [N_IN-1:0] idx,
    input  logic [N_IN-1:0] neg_mask,
    input  logic [7:0]      perm,
    output logic [N_IN-1:0] x
);

    // Route each (optionally inverted) sweep bit to the x input its perm field selects.
    always_comb begin
        x = '0;
        for (int i = 0; i < N_IN; i++) begin
            x[perm[2*i+:2]] = idx[i] ^ neg_mask[i];
        end
    end

endmodule

// File: rtl/npn4_tt_capture.sv
// Sweeps 16 minterms through an NPN transform into a network, samples y0 and
// assembles/compares the resulting 16-bit truth table.
module npn4_tt_capture
    import npn4_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_IN-1:0]  neg_mask,
    input  logic [7:0]       perm,
    input  logic             out_neg,
    input  logic [TT_W-1:0]  expected_tt,
    output logic [N_IN-1:0]  x_out,
    input  logic             y_in,
    output logic             busy,
    output logic             done,
    output logic [TT_W-1:0]  tt,
    output logic             match,
    output logic             perm_err
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_e            state_q, state_d;
    logic [N_IN-1:0]   idx_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [N_IN-1:0]   neg_q;
    logic [7:0]        perm_q;
    logic              out_neg_q;
    logic [TT_W-1:0]   exp_q;
    logic [N_IN-1:0]   x_q;
    logic [TT_W-1:0]   tt_q;
    logic              busy_q;
    logic              done_q;
    logic              match_q;
    logic              perm_err_q;

    logic [N_IN-1:0]   x_map;
    logic [TT_W-1:0]   tt_next;
    logic              perm_ok;

    npn4_input_map u_input_map (
        .idx      (idx_q),
        .neg_mask (neg_q),
        .perm     (perm_q),
        .x        (x_map)
    );

    assign perm_ok = perm_valid(perm_q);

    // Truth table with the current minterm's sample merged in; used so the final
    // compare sees the fully updated table.
    always_comb begin
        tt_next         = tt_q;
        tt_next[idx_q]  = y_in ^ out_neg_q;
    end

    // Sweep state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Sweep sequencing.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StCheck;
            StCheck:  state_d = perm_ok ? StDrive : StIdle;
            StDrive:  state_d = StSettle;
            StSettle: if (cnt_q == CNT_LAST) state_d = StSample;
            StSample: state_d = (idx_q == 4'd15) ? StFinish : StDrive;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Datapath: config latch, x drive, settle count, sampling and result flags.
    // done is set on the edge entering its pulse cycle so it is high for exactly
    // one cycle (FINISH, or the IDLE cycle after a failed CHECK).
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= '0;
            perm_q     <= PERM_ID;
            out_neg_q  <= 1'b0;
            exp_q      <= '0;
            x_q        <= '0;
            tt_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            match_q    <= 1'b0;
            perm_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        neg_q      <= neg_mask;
                        perm_q     <= perm;
                        out_neg_q  <= out_neg;
                        exp_q      <= expected_tt;
                        tt_q       <= '0;
                        match_q    <= 1'b0;
                        perm_err_q <= 1'b0;
                        idx_q      <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                StCheck: begin
                    if (!perm_ok) begin
                        perm_err_q <= 1'b1;
                        tt_q       <= '0;
                        match_q    <= 1'b0;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                StDrive: begin
                    x_q   <= x_map;
                    cnt_q <= '0;
                end
                StSettle: begin
                    cnt_q <= cnt_q + 1'b1;
                end
                StSample: begin
                    tt_q <= tt_next;
                    if (idx_q == 4'd15) begin
                        match_q <= (tt_next == exp_q);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StFinish: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign x_out    = x_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tt       = tt_q;
    assign match    = match_q;
    assign perm_err = perm_err_q;

endmodule

// File: tb/tb_npn4_tt_capture.sv
// Directed bench for npn4_tt_capture with a stub network y0 = x0 & x1.
module tb_npn4_tt_capture;
    import npn4_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  neg_mask;
    logic [7:0]  perm;
    logic        out_neg;
    logic [15:0] expected_tt;
    logic [3:0]  x_out;
    logic        y_in;
    logic        busy;
    logic        done;
    logic [15:0] tt;
    logic        match;
    logic        perm_err;

    int total;
    int bad;

    npn4_tt_capture #(
        .SETTLE_CYCLES (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .neg_mask    (neg_mask),
        .perm        (perm),
        .out_neg     (out_neg),
        .expected_tt (expected_tt),
        .x_out       (x_out),
        .y_in        (y_in),
        .busy        (busy),
        .done        (done),
        .tt          (tt),
        .match       (match),
        .perm_err    (perm_err)
    );

    assign y_in = x_out[0] & x_out[1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start with a config, scramble the config inputs afterwards, and wait
    // (bounded) for done. Returns the start->done latency in cycles (-1 on timeout),
    // busy one cycle after start, and whether x_out ever left 0. On success, steps
    // one more cycle so the DUT is idle on return.
    task automatic do_sweep(input logic [3:0] n, input logic [7:0] p, input logic on,
                            input logic [15:0] e, output int lat, output logic busy1,
                            output logic x_moved);
        neg_mask    = n;
        perm        = p;
        out_neg     = on;
        expected_tt = e;
        start       = 1'b1;
        lat         = -1;
        x_moved     = 1'b0;
        @(negedge clk);
        start       = 1'b0;
        neg_mask    = ~n;
        perm        = 8'h00;
        out_neg     = ~on;
        expected_tt = ~e;
        busy1       = busy;
        for (int c = 1; c <= 200; c++) begin
            if (x_out !== 4'h0) x_moved = 1'b1;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        if (lat > 0) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        total += 6;
        if (x_out !== 4'h0) begin bad++; $display("FAIL reset_x_out got=%h want=0", x_out); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        if (tt !== 16'h0) begin bad++; $display("FAIL reset_tt got=%h want=0000", tt); end
        if (match !== 1'b0) begin bad++; $display("FAIL reset_match got=%b want=0", match); end
        if (perm_err !== 1'b0) begin bad++; $display("FAIL reset_perm_err got=%b want=0", perm_err); end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL start_with_rst_busy got=%b want=0", busy); end
    endtask

    task automatic test_perm_err();
        int   lat;
        logic b1;
        logic xm;
        do_sweep(4'h0, 8'h00, 1'b0, 16'h8888, lat, b1, xm);
        total += 5;
        if (lat != 2) begin bad++; $display("FAIL perm_err_latency got=%0d want=2", lat); end
        if (perm_err !== 1'b1) begin bad++; $display("FAIL perm_err_flag got=%b want=1", perm_err); end
        if (tt !== 16'h0) begin bad++; $display("FAIL perm_err_tt got=%h want=0000", tt); end
        if (match !== 1'b0) begin bad++; $display("FAIL perm_err_match got=%b want=0", match); end
        if (xm !== 1'b0) begin bad++; $display("FAIL perm_err_x_moved got=%b want=0", xm); end
    endtask

    task automatic test_identity();
        int   lat;
        logic b1;
        logic xm;
        do_sweep(4'h0, PERM_ID, 1'b0, 16'h8888, lat, b1, xm);
        total += 7;
        if (lat != 50) begin bad++; $display("FAIL ident_latency got=%0d want=50", lat); end
        if (b1 !== 1'b1) begin bad++; $display("FAIL ident_busy got=%b want=1", b1); end
        if (tt !== 16'h8888) begin bad++; $display("FAIL ident_tt got=%h want=8888", tt); end
        if (match !== 1'b1) begin bad++; $display("FAIL ident_match got=%b want=1", match); end
        if (perm_err !== 1'b0) begin bad++; $display("FAIL ident_perm_err got=%b want=0", perm_err); end
        if (x_out !== 4'hF) begin bad++; $display("FAIL ident_x_last got=%h want=f", x_out); end
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL ident_idle got=done%b/busy%b want=done0/busy0", done, busy);
        end
        repeat (3) @(negedge clk);
        total++;
        if (tt !== 16'h8888 || match !== 1'b1) begin
            bad++; $display("FAIL ident_hold got=%h/%b want=8888/1", tt, match);
        end
    endtask

    task automatic test_out_neg();
        int   lat;
        logic b1;
        logic xm;
        do_sweep(4'h0, PERM_ID, 1'b1, 16'h8888, lat, b1, xm);
        total += 3;
        if (lat != 50) begin bad++; $display("FAIL outneg_latency got=%0d want=50", lat); end
        if (tt !== 16'h7777) begin bad++; $display("FAIL outneg_tt got=%h want=7777", tt); end
        if (match !== 1'b0) begin bad++; $display("FAIL outneg_match got=%b want=0", match); end
    endtask

    task automatic test_neg_perm();
        int   lat;
        logic b1;
        logic xm;
        do_sweep(4'b0001, PERM_ID, 1'b0, 16'h4444, lat, b1, xm);
        total += 2;
        if (tt !== 16'h4444) begin bad++; $display("FAIL neg0_tt got=%h want=4444", tt); end
        if (match !== 1'b1) begin bad++; $display("FAIL neg0_match got=%b want=1", match); end
        do_sweep(4'h0, 8'hC6, 1'b0, 16'h0000, lat, b1, xm);
        total += 2;
        if (tt !== 16'hC0C0) begin bad++; $display("FAIL perm_c6_tt got=%h want=c0c0", tt); end
        if (match !== 1'b0) begin bad++; $display("FAIL perm_c6_match got=%b want=0", match); end
        // Reversed order: y = k3 & k2.
        do_sweep(4'h0, 8'h1B, 1'b0, 16'hF000, lat, b1, xm);
        total += 2;
        if (tt !== 16'hF000) begin bad++; $display("FAIL perm_1b_tt got=%h want=f000", tt); end
        if (match !== 1'b1) begin bad++; $display("FAIL perm_1b_match got=%b want=1", match); end
    endtask

    task automatic test_reset_mid();
        int   lat;
        logic b1;
        logic xm;
        neg_mask = 4'h0; perm = PERM_ID; out_neg = 1'b0; expected_tt = 16'h8888;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({x_out, busy, done, tt, match, perm_err} !== 24'h0) begin
            bad++;
            $display("FAIL mid_reset got=x%h b%b d%b tt%h m%b pe%b want=all0",
                     x_out, busy, done, tt, match, perm_err);
        end
        do_sweep(4'h0, 8'hC6, 1'b0, 16'hC0C0, lat, b1, xm);
        total += 3;
        if (lat != 50) begin bad++; $display("FAIL after_rst_latency got=%0d want=50", lat); end
        if (tt !== 16'hC0C0) begin bad++; $display("FAIL after_rst_tt got=%h want=c0c0", tt); end
        if (match !== 1'b1) begin bad++; $display("FAIL after_rst_match got=%b want=1", match); end
    endtask

    task automatic test_start_ignored();
        int dones;
        int first;
        neg_mask = 4'h0; perm = PERM_ID; out_neg = 1'b0; expected_tt = 16'h8888;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        first = -1;
        for (int c = 1; c <= 120; c++) begin
            if (done === 1'b1) begin
                dones++;
                if (first < 0) first = c;
            end
            // Extra starts with a bad config while busy must be ignored.
            if (c == 5 || c == 20 || c == 40) begin
                neg_mask = 4'hF; perm = 8'h00; out_neg = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        total += 4;
        if (dones != 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", dones); end
        if (first != 50) begin bad++; $display("FAIL ignore_latency got=%0d want=50", first); end
        if (tt !== 16'h8888) begin bad++; $display("FAIL ignore_tt got=%h want=8888", tt); end
        if (perm_err !== 1'b0) begin bad++; $display("FAIL ignore_perm_err got=%b want=0", perm_err); end
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic b1;
        logic xm;
        do_sweep(4'h0, PERM_ID, 1'b1, 16'h7777, lat, b1, xm);
        total += 2;
        if (tt !== 16'h7777) begin bad++; $display("FAIL b2b_first_tt got=%h want=7777", tt); end
        if (match !== 1'b1) begin bad++; $display("FAIL b2b_first_match got=%b want=1", match); end
        // do_sweep returns in the cycle after done, so this start lands there.
        do_sweep(4'b0001, PERM_ID, 1'b0, 16'h4444, lat, b1, xm);
        total += 3;
        if (lat != 50) begin bad++; $display("FAIL b2b_latency got=%0d want=50", lat); end
        if (tt !== 16'h4444) begin bad++; $display("FAIL b2b_second_tt got=%h want=4444", tt); end
        if (match !== 1'b1) begin bad++; $display("FAIL b2b_second_match got=%b want=1", match); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        start = 1'b0;
        neg_mask = 4'h0;
        perm = PERM_ID;
        out_neg = 1'b0;
        expected_tt = 16'h0;
        @(negedge clk);
        test_reset();
        test_perm_err();
        test_identity();
        test_out_neg();
        test_neg_perm();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
